// File: rtl/dmem_dump_if.sv
// Byte stream from the dmem dumper to its sink.
// Ports: out_valid/out_data/out_last (master->slave), out_ready (slave->master).
interface dmem_dump_if #(
  parameter int DATA_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/dmem_dump.sv
// Walks a dmem window after core done and streams each word out; holds the core meanwhile.
// Ports: clk, reset (async low), done, rd_adr/rd_data, out (stream master), cpu_hold, dump_done.
// Option: DMEM_DUMP_CHECKSUM_EN appends a sum-of-words beat as the final beat.
module dmem_dump #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0,
  parameter int LEN        = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [DATA_W-1:0] rd_data,
  dmem_dump_if.master       out,
  output logic              cpu_hold,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W:0]   LAST  = (ADDR_W+1)'(LEN-1);

`ifdef DMEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, DONE, CHK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, SEND, DONE
  } state_t;
`endif

  state_t            state_q, state_n;
  logic              done_q;
  logic              start;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W:0]   cnt_q, cnt_n;
  logic              vld_q, vld_n;
  logic [DATA_W-1:0] dat_q, dat_n;
  logic              lst_q, lst_n;
  logic              hold_q, hold_n;
  logic              dd_q, dd_n;
  logic              acc;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_n;
`endif

  assign start = done & ~done_q;
  assign acc   = vld_q & out.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      addr_q  <= START;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      lst_q   <= 1'b0;
      hold_q  <= 1'b0;
      dd_q    <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      done_q  <= done;
      addr_q  <= addr_n;
      cnt_q   <= cnt_n;
      vld_q   <= vld_n;
      dat_q   <= dat_n;
      lst_q   <= lst_n;
      hold_q  <= hold_n;
      dd_q    <= dd_n;
`ifdef DMEM_DUMP_CHECKSUM_EN
      sum_q   <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    vld_n   = vld_q;
    dat_n   = dat_q;
    lst_n   = lst_q;
    hold_n  = hold_q;
    dd_n    = dd_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
    sum_n   = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          addr_n  = START;
          cnt_n   = '0;
          hold_n  = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
          sum_n   = '0;
`endif
        end
      end
      FETCH: begin
        dat_n   = rd_data;
        vld_n   = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
        lst_n   = 1'b0;
`else
        lst_n   = (cnt_q == LAST);
`endif
        state_n = SEND;
      end
      SEND: begin
        if (acc) begin
          vld_n = 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
          sum_n = sum_q + dat_q;
          if (cnt_q == LAST) begin
            // checksum beat follows immediately
            vld_n   = 1'b1;
            dat_n   = sum_q + dat_q;
            lst_n   = 1'b1;
            state_n = CHK;
          end else begin
            addr_n  = addr_q + 1'b1;
            cnt_n   = cnt_q + 1'b1;
            state_n = FETCH;
          end
`else
          if (lst_q) begin
            state_n = DONE;
            hold_n  = 1'b0;
            dd_n    = 1'b1;
          end else begin
            addr_n  = addr_q + 1'b1;
            cnt_n   = cnt_q + 1'b1;
            state_n = FETCH;
          end
`endif
        end
      end
`ifdef DMEM_DUMP_CHECKSUM_EN
      CHK: begin
        if (acc) begin
          vld_n   = 1'b0;
          state_n = DONE;
          hold_n  = 1'b0;
          dd_n    = 1'b1;
        end
      end
`endif
      DONE: begin
        if (!done) begin
          state_n = IDLE;
          dd_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // addr only moves on entry to FETCH, so it holds outside FETCH
  assign rd_adr        = addr_q;
  assign out.out_valid = vld_q;
  assign out.out_data  = dat_q;
  assign out.out_last  = lst_q;
  assign cpu_hold      = hold_q;
  assign dump_done     = dd_q;

endmodule

// File: tb/tb_dmem_dump.sv
// Directed bench for dmem_dump: three instances share done/ready/reset.
// u0 START=8 LEN=4, u1 START=254 LEN=4 (wrap), u2 START=16 LEN=2.
module tb_dmem_dump;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] a0, a1, a2;
  logic       h0, h1, h2, d0, d1, d2;

  int errs = 0;
  int checks = 0;

  logic [7:0] qd0[$], qd1[$], qd2[$], qa1[$];
  logic       ql0[$], ql1[$], ql2[$];
  logic [7:0] e0[$], e1[$], e2[$];

  always #5 clk = ~clk;

  dmem_dump_if #(.DATA_W(8)) s0 ();
  dmem_dump_if #(.DATA_W(8)) s1 ();
  dmem_dump_if #(.DATA_W(8)) s2 ();

  assign s0.out_ready = ready;
  assign s1.out_ready = ready;
  assign s2.out_ready = ready;

  dmem_dump #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8), .LEN(4)) u0 (
    .clk(clk), .reset(rst_n), .done(done), .rd_adr(a0),
    .rd_data(mem[a0]), .out(s0), .cpu_hold(h0), .dump_done(d0)
  );
  dmem_dump #(.ADDR_W(8), .DATA_W(8), .START_ADDR(254), .LEN(4)) u1 (
    .clk(clk), .reset(rst_n), .done(done), .rd_adr(a1),
    .rd_data(mem[a1]), .out(s1), .cpu_hold(h1), .dump_done(d1)
  );
  dmem_dump #(.ADDR_W(8), .DATA_W(8), .START_ADDR(16), .LEN(2)) u2 (
    .clk(clk), .reset(rst_n), .done(done), .rd_adr(a2),
    .rd_data(mem[a2]), .out(s2), .cpu_hold(h2), .dump_done(d2)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s0.out_valid && s0.out_ready) begin
      qd0.push_back(s0.out_data);
      ql0.push_back(s0.out_last);
      check("hold0", 32'(h0), 1);
    end
    if (s1.out_valid && s1.out_ready) begin
      qd1.push_back(s1.out_data);
      ql1.push_back(s1.out_last);
      qa1.push_back(a1);
      check("hold1", 32'(h1), 1);
    end
    if (s2.out_valid && s2.out_ready) begin
      qd2.push_back(s2.out_data);
      ql2.push_back(s2.out_last);
      check("hold2", 32'(h2), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string tag, input logic [7:0] got[$],
                     input logic gl[$], input logic [7:0] exp[$]);
    check({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check({tag, "_d"}, 32'(got[i]), 32'(exp[i]));
      check({tag, "_l"}, 32'(gl[i]), 32'(i == exp.size() - 1));
    end
  endtask

  task automatic cmp_all();
    logic [7:0] ea[4];
    ea = '{8'd254, 8'd255, 8'd0, 8'd1};
    cmp("u0", qd0, ql0, e0);
    cmp("u1", qd1, ql1, e1);
    cmp("u2", qd2, ql2, e2);
    for (int i = 0; i < 4 && i < qa1.size(); i++)
      check("u1_adr", 32'(qa1[i]), 32'(ea[i]));
    qd0.delete(); qd1.delete(); qd2.delete(); qa1.delete();
    ql0.delete(); ql1.delete(); ql2.delete();
  endtask

  task automatic clear_q();
    qd0.delete(); qd1.delete(); qd2.delete(); qa1.delete();
    ql0.delete(); ql1.delete(); ql2.delete();
  endtask

  task automatic wait_dumps();
    for (int i = 0; i < 300; i++) begin
      if (d0 && d1 && d2) break;
      tick();
    end
    check("dump_to", 32'(d0 && d1 && d2), 1);
  endtask

  task automatic wait_beat(logic [7:0] v);
    for (int i = 0; i < 40; i++) begin
      if (s0.out_valid && s0.out_data == v) break;
      tick();
    end
    check("beat_to", 32'(s0.out_valid && s0.out_data == v), 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
    mem[254] = 8'hA1; mem[255] = 8'hA2; mem[0] = 8'hA3; mem[1] = 8'hA4;
    mem[16] = 8'hF0; mem[17] = 8'h20;
    e0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    e1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    e2 = '{8'hF0, 8'h20};
`ifdef DMEM_DUMP_CHECKSUM_EN
    e0.push_back(8'hAA);
    e1.push_back(8'h8A);
    e2.push_back(8'h10);
`endif

    repeat (2) tick();
    check("rst_vld", 32'(s0.out_valid), 0);
    check("rst_dat", 32'(s0.out_data), 0);
    check("rst_lst", 32'(s0.out_last), 0);
    check("rst_hold", 32'(h0), 0);
    check("rst_dd", 32'(d0), 0);
    check("rst_adr0", 32'(a0), 8);
    check("rst_adr1", 32'(a1), 254);
    rst_n = 1'b1;
    repeat (2) tick();

    // normal dump, ready always high, latency check
    ready = 1'b1;
    done = 1'b1;
    tick();
    check("lat_vld0", 32'(s0.out_valid), 0);
    check("lat_hold", 32'(h0), 1);
    tick();
    check("lat_vld1", 32'(s0.out_valid), 1);
    check("lat_dat", 32'(s0.out_data), 8'h11);
    check("lat_adr", 32'(a0), 8);
    wait_dumps();
    check("end_hold", 32'(h0), 0);
    check("end_dd", 32'(d0), 1);
    cmp_all();

    // done held high: no second dump
    repeat (10) tick();
    check("no_redump", qd0.size(), 0);
    check("dd_held", 32'(d0), 1);
    done = 1'b0;
    tick();
    check("dd_clr", 32'(d0), 0);
    repeat (2) tick();

    // backpressure on beat 2
    done = 1'b1;
    wait_beat(8'h22);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_dat", 32'(s0.out_data), 8'h22);
      check("stall_vld", 32'(s0.out_valid), 1);
    end
    ready = 1'b1;
    wait_dumps();
    cmp_all();
    done = 1'b0;
    repeat (3) tick();

    // reset mid-dump on beat 3
    done = 1'b1;
    wait_beat(8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_vld", 32'(s0.out_valid), 0);
    check("abort_dat", 32'(s0.out_data), 0);
    check("abort_lst", 32'(s0.out_last), 0);
    check("abort_hold", 32'(h0), 0);
    check("abort_dd", 32'(d0), 0);
    check("abort_adr", 32'(a0), 8);
    clear_q();
    tick();
    rst_n = 1'b1;
    done = 1'b0;
    repeat (2) tick();
    check("idle_vld", 32'(s0.out_valid), 0);
    done = 1'b1;
    wait_dumps();
    cmp_all();
    done = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
